pulse_sequencer: RTL

PULSE_SEQUENCER -- requirements
Module: pulse_sequencer

---
 rtl/pulse_sequencer_pkg.sv | 18 +
 rtl/pulse_seq_timer.sv | 46 ++++
 rtl/pulse_sequencer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// pulse_sequencer_pkg
// Shared definitions for the pulse sequencer: the FSM state encoding and the
// default counter width used by the top level and its timer.
// -----------------------------------------------------------------------------
package pulse_sequencer_pkg;

  // Default width of the period / pulse-width counters.
  localparam int CNT_W_DEFAULT = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HIGH  = 2'd1,
    ST_LOW   = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

endpackage : pulse_sequencer_pkg

// File: rtl/pulse_seq_timer.sv
// -----------------------------------------------------------------------------
// pulse_seq_timer
// Loadable down-counter. A load takes priority; otherwise the count decrements
// and holds at zero (it never wraps). tc flags the last cycle of a loaded
// interval, so loading N gives tc exactly N cycles later.
//
// Ports
//   clk       in  1  rising-edge clock
//   rstn      in  1  asynchronous active-low reset
//   load      in  1  load load_val this cycle
//   load_val  in  W  interval length in clk cycles
//   tc        out 1  terminal count (count == 1)
// -----------------------------------------------------------------------------
module pulse_seq_timer #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge inputs regardless of process ordering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == W'(1));

endmodule : pulse_seq_timer

// File: rtl/pulse_sequencer.sv
// -----------------------------------------------------------------------------
// pulse_sequencer
// Periodic pulse generator with config shadowing, width clamping, latched
// fault handling and an optional burst mode.
//
// Build option: define PULSE_SEQ_BURST_EN to enable burst mode
// (cfg_burst_count pulses, then burst_done and lock until enable goes low).
// Without it cfg_burst_count is ignored, operation is always continuous and
// burst_done is tied low.
//
// Ports
//   clk              in  1      rising-edge clock
//   rstn             in  1      asynchronous active-low reset
//   cfg_period       in  CNT_W  period in clk cycles
//   cfg_pulse_width  in  CNT_W  high time in clk cycles
//   cfg_enable       in  1      run request (level)
//   cfg_burst_count  in  16     pulses per burst, 0 = continuous
//   fault_in         in  1      fault monitor (level)
//   fault_clr        in  1      clears a latched fault (strobe)
//   pulse_out        out 1      registered drive pulse
//   pulse_start      out 1      strobe on each pulse rising edge
//   busy             out 1      high in HIGH or LOW
//   fault_latched    out 1      high in FAULT
//   burst_done       out 1      strobe at end of a burst
// -----------------------------------------------------------------------------
module pulse_sequencer
  import pulse_sequencer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_pulse_width,
  input  logic             cfg_enable,
  input  logic [15:0]      cfg_burst_count,
  input  logic             fault_in,
  input  logic             fault_clr,
  output logic             pulse_out,
  output logic             pulse_start,
  output logic             busy,
  output logic             fault_latched,
  output logic             burst_done
);

  state_e           state_q, state_d;
  logic             pulse_out_q, pulse_out_d;
  logic             pulse_start_q, pulse_start_d;
  logic             burst_done_q, burst_done_d;
  logic             abort_q, abort_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] width_q, width_d;

  logic [CNT_W-1:0] eff_width;
  logic             cfg_ok;
  logic             start_ok;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_tc;
  logic             burst_end;
  logic             locked;

  // Width as it will be shadowed: clamped to period-1. A period of 0 or 1
  // yields width 0, which is the "no pulse" condition.
  always_comb begin
    if (cfg_period == '0) begin
      eff_width = '0;
    end else if (cfg_pulse_width >= cfg_period) begin
      eff_width = cfg_period - CNT_W'(1);
    end else begin
      eff_width = cfg_pulse_width;
    end
  end

  assign cfg_ok   = (eff_width != '0);
  assign start_ok = cfg_enable && !fault_in && cfg_ok && !locked;

  pulse_seq_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rstn     (rstn),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  always_comb begin
    state_d       = state_q;
    pulse_out_d   = 1'b0;
    pulse_start_d = 1'b0;
    burst_done_d  = 1'b0;
    abort_d       = abort_q;
    period_d      = period_q;
    width_d       = width_q;
    tmr_load      = 1'b0;
    tmr_val       = eff_width;

    unique case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d       = ST_HIGH;
          pulse_out_d   = 1'b1;
          pulse_start_d = 1'b1;
          period_d      = cfg_period;
          width_d       = eff_width;
          tmr_load      = 1'b1;
        end
      end

      ST_HIGH: begin
        pulse_out_d = 1'b1;
        // A stop request seen at any point of the high phase is remembered
        // so the pulse still completes at full width before going idle.
        if (!cfg_enable) abort_d = 1'b1;
        if (tmr_tc) begin
          pulse_out_d = 1'b0;
          abort_d     = 1'b0;
          if (abort_q || !cfg_enable) begin
            state_d = ST_IDLE;
          end else begin
            state_d  = ST_LOW;
            tmr_load = 1'b1;
            tmr_val  = period_q - width_q;
          end
        end
      end

      ST_LOW: begin
        if (!cfg_enable) begin
          state_d = ST_IDLE;
        end else if (tmr_tc) begin
          if (burst_end) begin
            state_d      = ST_IDLE;
            burst_done_d = 1'b1;
          end else if (cfg_ok) begin
            // Period boundary: the only point besides start where new
            // configuration is taken into the shadows.
            state_d       = ST_HIGH;
            pulse_out_d   = 1'b1;
            pulse_start_d = 1'b1;
            period_d      = cfg_period;
            width_d       = eff_width;
            tmr_load      = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_FAULT: begin
        if (fault_clr && !fault_in) state_d = ST_IDLE;
      end
    endcase

    // Fault overrides everything, including a pending burst completion.
    if (fault_in) begin
      state_d       = ST_FAULT;
      pulse_out_d   = 1'b0;
      pulse_start_d = 1'b0;
      burst_done_d  = 1'b0;
      abort_d       = 1'b0;
      tmr_load      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: the config shadows are reset like every other flop here so the
    // block leaves reset in a fully defined state.
    if (!rstn) begin
      state_q       <= ST_IDLE;
      pulse_out_q   <= 1'b0;
      pulse_start_q <= 1'b0;
      burst_done_q  <= 1'b0;
      abort_q       <= 1'b0;
      period_q      <= '0;
      width_q       <= '0;
    end else begin
      state_q       <= state_d;
      pulse_out_q   <= pulse_out_d;
      pulse_start_q <= pulse_start_d;
      burst_done_q  <= burst_done_d;
      abort_q       <= abort_d;
      period_q      <= period_d;
      width_q       <= width_d;
    end
  end

`ifdef PULSE_SEQ_BURST_EN
  logic [15:0] pulse_cnt_q, pulse_cnt_d;
  logic        lock_q, lock_d;

  // The burst ends once the pulse that completed its period was the Nth.
  assign burst_end = (cfg_burst_count != 16'd0) && (pulse_cnt_q >= cfg_burst_count);
  assign locked    = lock_q;

  always_comb begin
    pulse_cnt_d = pulse_cnt_q;
    lock_d      = lock_q;
    if (pulse_start_d) begin
      if (state_q == ST_IDLE) begin
        pulse_cnt_d = 16'd1;
      end else if (pulse_cnt_q != 16'hFFFF) begin
        pulse_cnt_d = pulse_cnt_q + 16'd1;
      end
    end
    if (burst_done_d) begin
      lock_d = 1'b1;
    end else if (!cfg_enable) begin
      lock_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pulse_cnt_q <= '0;
      lock_q      <= 1'b0;
    end else begin
      pulse_cnt_q <= pulse_cnt_d;
      lock_q      <= lock_d;
    end
  end
`else
  logic unused_burst_count;

  assign unused_burst_count = ^cfg_burst_count;
  assign burst_end          = 1'b0;
  assign locked             = 1'b0;
`endif

  assign pulse_out     = pulse_out_q;
  assign pulse_start   = pulse_start_q;
  assign burst_done    = burst_done_q;
  assign busy          = (state_q == ST_HIGH) || (state_q == ST_LOW);
  assign fault_latched = (state_q == ST_FAULT);

endmodule : pulse_sequencer
